// File: rtl/flood_it_pkg.sv
// Shared types for the Flood-It input path: command encoding and button indices.
package flood_it_pkg;

   typedef enum logic [2:0] {
      NONE   = 3'd0,
      SELECT = 3'd1,
      UP     = 3'd2,
      DOWN   = 3'd3,
      LEFT   = 3'd4,
      RIGHT  = 3'd5
   } cmd_e;

   localparam int NUM_BTN = 5;

   localparam logic [2:0] BTN_C = 3'd0;
   localparam logic [2:0] BTN_U = 3'd1;
   localparam logic [2:0] BTN_D = 3'd2;
   localparam logic [2:0] BTN_L = 3'd3;
   localparam logic [2:0] BTN_R = 3'd4;

   function automatic cmd_e btn_to_cmd(input logic [2:0] idx);
      cmd_e c;
      case (idx)
         BTN_C:   c = SELECT;
         BTN_U:   c = UP;
         BTN_D:   c = DOWN;
         BTN_L:   c = LEFT;
         BTN_R:   c = RIGHT;
         default: c = NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit conditioner: 2-flop synchronizer followed by a stable-count debouncer.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = ~level_q;
         cnt_d   = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_level = level_q;

endmodule

// File: rtl/btn_cmd_decoder.sv
// Button-to-command front end: debounce, press detection, priority, auto-repeat, one-deep buffer.
// state    | meaning
// R_IDLE   | no directional button armed for repeat
// R_DELAY  | waiting for the first auto-repeat of rep_btn
// R_PERIOD | issuing periodic auto-repeats of rep_btn
// B_EMPTY  | output buffer holds no command
// B_FULL   | cmd_valid asserted, command waiting for cmd_ready
module btn_cmd_decoder
   import flood_it_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 40000000,
   parameter int REPEAT_PERIOD   = 15000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn_raw,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic       cmd_repeat,
   input  logic       cmd_ready,
   output logic [4:0] btn_level,
   output logic       overflow,
   input  logic       ovf_clr
);

   localparam logic [1:0] R_IDLE   = 2'd0;
   localparam logic [1:0] R_DELAY  = 2'd1;
   localparam logic [1:0] R_PERIOD = 2'd2;

   localparam logic B_EMPTY = 1'b0;
   localparam logic B_FULL  = 1'b1;

   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
   localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

   logic [4:0] level;
   logic [4:0] level_dly_q, level_dly_d;
   logic [4:0] press_q, press_d;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_raw   (btn_raw[g]),
         .btn_level (level[g])
      );
   end

   // Press pulse is registered so the buffer sees it one cycle after the level rises.
   assign level_dly_d = level;
   assign press_d     = level & ~level_dly_q;

   logic       press_any, press_multi, press_dir;
   logic [2:0] win_idx;

   always_comb begin
      win_idx = BTN_C;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (press_q[i]) win_idx = 3'(i);
      end
   end

   assign press_any   = |press_q;
   assign press_multi = |(press_q & (press_q - 5'd1));
   assign press_dir   = press_any && (win_idx != BTN_C);

   logic [1:0]     rep_state_q, rep_state_d;
   logic [2:0]     rep_btn_q, rep_btn_d;
   logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
   logic [RCW-1:0] rep_last;
   logic           rep_hit, rep_ev;

   always_comb begin
      rep_state_d = rep_state_q;
      rep_btn_d   = rep_btn_q;
      rep_cnt_d   = rep_cnt_q;
      rep_hit     = 1'b0;
      rep_last    = (rep_state_q == R_DELAY) ? DELAY_LAST : PERIOD_LAST;
      if (press_dir) begin
         rep_state_d = R_DELAY;
         rep_btn_d   = win_idx;
         rep_cnt_d   = '0;
      end else if (rep_state_q != R_IDLE) begin
         if (!level[rep_btn_q]) begin
            rep_state_d = R_IDLE;
            rep_cnt_d   = '0;
         end else if (rep_cnt_q == rep_last) begin
            rep_hit     = 1'b1;
            rep_state_d = R_PERIOD;
            rep_cnt_d   = '0;
         end else if (rep_cnt_q != '1) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end
   end

   // A coincident press of any button takes the buffer slot instead of the repeat.
   assign rep_ev = rep_hit & ~press_any;

   logic buf_state_q, buf_state_d;
   logic [2:0] code_q, code_d;
   logic rep_flag_q, rep_flag_d;
   logic ovf_q, ovf_d;
   logic handshake, can_load, ovf_set;
   cmd_e ev_code;

   assign handshake = (buf_state_q == B_FULL) && cmd_ready;
   assign can_load  = (buf_state_q == B_EMPTY) || handshake;
   assign ev_code   = press_any ? btn_to_cmd(win_idx) : btn_to_cmd(rep_btn_q);
   assign ovf_set   = press_multi || (press_any && !can_load);

   always_comb begin
      buf_state_d = buf_state_q;
      code_d      = code_q;
      rep_flag_d  = rep_flag_q;
      if (handshake) buf_state_d = B_EMPTY;
      if ((press_any || rep_ev) && can_load) begin
         buf_state_d = B_FULL;
         code_d      = ev_code;
         rep_flag_d  = ~press_any;
      end
      ovf_d = ovf_q;
      if (ovf_set)      ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_dly_q <= '0;
         press_q     <= '0;
         rep_state_q <= R_IDLE;
         rep_btn_q   <= BTN_C;
         rep_cnt_q   <= '0;
         buf_state_q <= B_EMPTY;
         code_q      <= '0;
         rep_flag_q  <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         level_dly_q <= level_dly_d;
         press_q     <= press_d;
         rep_state_q <= rep_state_d;
         rep_btn_q   <= rep_btn_d;
         rep_cnt_q   <= rep_cnt_d;
         buf_state_q <= buf_state_d;
         code_q      <= code_d;
         rep_flag_q  <= rep_flag_d;
         ovf_q       <= ovf_d;
      end
   end

   assign cmd_valid  = (buf_state_q == B_FULL);
   assign cmd_code   = code_q;
   assign cmd_repeat = rep_flag_q;
   assign btn_level  = level;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_btn_cmd_decoder.sv
// Directed bench for btn_cmd_decoder with short debounce/repeat parameters.
module tb_btn_cmd_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] btn_raw;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic       cmd_repeat;
   logic       cmd_ready;
   logic [4:0] btn_level;
   logic       overflow;
   logic       ovf_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   btn_cmd_decoder #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .cmd_repeat (cmd_repeat),
      .cmd_ready  (cmd_ready),
      .btn_level  (btn_level),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      btn_raw = 5'b0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn_raw = 5'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", cmd_valid); end
      checks++; if (cmd_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", cmd_code); end
      checks++; if (cmd_repeat !== 1'b0) begin errors++; $display("FAIL reset_repeat got %0b want 0", cmd_repeat); end
      checks++; if (btn_level !== 5'd0) begin errors++; $display("FAIL reset_level got %b want 00000", btn_level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_press();
      cmd_ready = 1'b1;
      btn_raw = 5'b00010;
      for (int e = 0; e <= 8; e++) begin
         tick();
         checks++;
         if (cmd_valid !== (e == 7)) begin
            errors++; $display("FAIL press_latency edge %0d valid %0b want %0b", e, cmd_valid, (e == 7));
         end
         if (e == 7) begin
            checks++; if (cmd_code !== 3'd2) begin errors++; $display("FAIL press_code got %0d want 2", cmd_code); end
            checks++; if (cmd_repeat !== 1'b0) begin errors++; $display("FAIL press_repeat got %0b want 0", cmd_repeat); end
            checks++; if (btn_level[1] !== 1'b1) begin errors++; $display("FAIL press_level got %b want bit1 set", btn_level); end
         end
      end
      btn_raw = 5'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL release_no_cmd cycle %0d valid %0b want 0", i, cmd_valid); end
      end
   endtask

   task automatic test_glitch();
      btn_raw = 5'b00001;
      repeat (3) tick();
      btn_raw = 5'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if (btn_level !== 5'd0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL glitch cycle %0d level %b valid %0b want 00000/0", i, btn_level, cmd_valid);
         end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL glitch_ovf got %0b want 0", overflow); end
   endtask

   task automatic test_repeat();
      logic exp_v;
      cmd_ready = 1'b1;
      btn_raw = 5'b01000;
      for (int e = 0; e <= 44; e++) begin
         tick();
         exp_v = (e == 7) || (e == 27) || (e == 35) || (e == 43);
         checks++;
         if (cmd_valid !== exp_v) begin
            errors++; $display("FAIL repeat_timing edge %0d valid %0b want %0b", e, cmd_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (cmd_code !== 3'd4 || cmd_repeat !== (e != 7)) begin
               errors++; $display("FAIL repeat_cmd edge %0d code %0d rep %0b want 4/%0b", e, cmd_code, cmd_repeat, (e != 7));
            end
         end
      end
      btn_raw = 5'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL repeat_release cycle %0d valid %0b want 0", i, cmd_valid); end
      end
      checks++; if (dut.rep_state_q !== 2'd0) begin errors++; $display("FAIL repeat_idle state %0d want 0", dut.rep_state_q); end
   endtask

   task automatic test_overflow();
      cmd_ready = 1'b0;
      btn_raw = 5'b10000;
      repeat (8) tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd5) begin errors++; $display("FAIL ovf_first valid %0b code %0d want 1/5", cmd_valid, cmd_code); end
      btn_raw = 5'b10100;
      repeat (10) tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd5 || cmd_repeat !== 1'b0) begin
         errors++; $display("FAIL ovf_hold valid %0b code %0d rep %0b want 1/5/0", cmd_valid, cmd_code, cmd_repeat);
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
      checks++; if (cmd_code !== 3'd5) begin errors++; $display("FAIL ovf_code_stable got %0d want 5", cmd_code); end
      btn_raw = 5'b0;
      cmd_ready = 1'b1;
      tick();
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_accept valid %0b want 0", cmd_valid); end
      settle(30);
   endtask

   task automatic test_simultaneous();
      cmd_ready = 1'b1;
      btn_raw = 5'b00011;
      repeat (8) tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin errors++; $display("FAIL simul_cmd valid %0b code %0d want 1/1", cmd_valid, cmd_code); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL simul_ovf got %0b want 1", overflow); end
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL simul_no_repeat cycle %0d valid %0b want 0", i, cmd_valid); end
      end
      checks++; if (dut.rep_state_q !== 2'd0) begin errors++; $display("FAIL simul_idle state %0d want 0", dut.rep_state_q); end
      settle(12);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf_clr got %0b want 0", overflow); end
   endtask

   task automatic test_back_to_back();
      cmd_ready = 1'b0;
      btn_raw = 5'b00010;
      repeat (8) tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin errors++; $display("FAIL b2b_first valid %0b code %0d want 1/2", cmd_valid, cmd_code); end
      btn_raw = 5'b01010;
      repeat (7) tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin errors++; $display("FAIL b2b_wait valid %0b code %0d want 1/2", cmd_valid, cmd_code); end
      cmd_ready = 1'b1;
      tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd4 || cmd_repeat !== 1'b0) begin
         errors++; $display("FAIL b2b_nobubble valid %0b code %0d rep %0b want 1/4/0", cmd_valid, cmd_code, cmd_repeat);
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %0b want 0", overflow); end
      tick();
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain valid %0b want 0", cmd_valid); end
      settle(30);
   endtask

   task automatic test_reset_mid_repeat();
      cmd_ready = 1'b1;
      btn_raw = 5'b00100;
      repeat (31) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || cmd_repeat !== 1'b0) begin
         errors++; $display("FAIL rst_mid_outputs valid %0b code %0d rep %0b want 0/0/0", cmd_valid, cmd_code, cmd_repeat);
      end
      checks++; if (btn_level !== 5'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_level level %b ovf %0b want 0", btn_level, overflow); end
      repeat (3) tick();
      checks++; if (cmd_valid !== 1'b0 || btn_level !== 5'd0) begin errors++; $display("FAIL rst_hold valid %0b level %b want 0", cmd_valid, btn_level); end
      @(negedge clk) rst_n = 1'b1;
      for (int e = 0; e <= 7; e++) begin
         tick();
         checks++;
         if (cmd_valid !== (e == 7)) begin
            errors++; $display("FAIL rst_repress edge %0d valid %0b want %0b", e, cmd_valid, (e == 7));
         end
      end
      checks++; if (cmd_code !== 3'd3 || cmd_repeat !== 1'b0) begin errors++; $display("FAIL rst_repress_cmd code %0d rep %0b want 3/0", cmd_code, cmd_repeat); end
      settle(20);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_repeat();
      test_overflow();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_repeat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_cmd_decoder.md
Name: btn_cmd_decoder

Overview:
- Input-side conditioner for the Flood-It top level: turns raw board buttons (btnC/U/D/L/R) into clean, single-shot game commands for the game controller.
- Handles each button in four stages: synchronisation, debounce, press-edge detection, and auto-repeat for directional buttons.
- Hands commands to the game FSM through a one-entry valid/ready buffer.
- Sits between the top-level button pins and the game-logic core.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized cycles needed to accept a level change (5 ms at 100 MHz).
- REPEAT_DELAY, 40000000: cycles from a directional press event to its first auto-repeat.
- REPEAT_PERIOD, 15000000: cycles between later auto-repeats.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  5  raw buttons, bit order {R,L,D,U,C} (bit0 = C); asynchronous to clk.
- cmd_valid  out  1  a command is pending.
- cmd_code  out  3  0 NONE, 1 SELECT, 2 UP, 3 DOWN, 4 LEFT, 5 RIGHT.
- cmd_repeat  out  1  pending command was produced by auto-repeat.
- cmd_ready  in  1  consumer accepts the command when cmd_valid && cmd_ready.
- btn_level  out  5  debounced button levels.
- overflow  out  1  sticky: a press event was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset: all flops cleared asynchronously on rst_n low.
  - cmd_valid=0, cmd_code=0, cmd_repeat=0, btn_level=0, overflow=0.
  - Synchronizers and counters are zeroed; repeat FSM goes to R_IDLE.
  - Reset asserted mid-debounce or mid-repeat aborts with no residual event.
  - A button held across reset release is seen as a fresh press once debounced.
- Synchronizer: 2-flop per bit.
- Debounce, per bit:
  - Counter increments while the sync value differs from btn_level; it clears to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_level toggles on that edge.
  - Glitches shorter than DEBOUNCE_CYCLES never change btn_level.
- Press event: rising edge of btn_level, 1-cycle pulse. Releases generate no command.
- Latency: a clean raw rise seen at edge 0 gives cmd_valid=1 after exactly 2+DEBOUNCE_CYCLES+1 edges (buffer empty).
- Simultaneous press events in one cycle:
  - Only the highest priority is issued: C > U > D > L > R.
  - The others are dropped and set overflow.
- Output buffer, states EMPTY / FULL:
  - EMPTY + event: load cmd_code and cmd_repeat, go FULL next edge.
  - FULL + handshake: go EMPTY. If an event arrives in the same cycle, load it and stay FULL (no bubble).
  - FULL without handshake: cmd_code and cmd_repeat are held stable.
  - A new press event while FULL and not accepted is dropped and sets overflow.
- Repeat FSM (directional buttons only), states R_IDLE / R_DELAY / R_PERIOD:
  - A directional press event latches rep_btn, clears the counter and enters R_DELAY. This also applies from R_DELAY or R_PERIOD, retargeting to the new button.
  - R_DELAY: when the counter reaches REPEAT_DELAY-1, emit a repeat event, clear the counter and enter R_PERIOD.
  - R_PERIOD: emit a repeat event every REPEAT_PERIOD cycles.
  - Repeat events carry cmd_repeat=1.
  - A repeat event that cannot load because the buffer is FULL is dropped silently; overflow is not set.
  - Debounced release of rep_btn goes to R_IDLE in the same cycle, and no repeat is emitted on that cycle.
  - A SELECT press does not affect the repeat FSM.
  - If a press event and a repeat event coincide, the press event wins and the repeat is discarded.
- overflow: set by the conditions above.
  - ovf_clr=1 clears it.
  - If set and clear happen in the same cycle, set wins.
- Counter widths: $clog2 of the respective parameter. Counters saturate and never wrap.

Decomposition:
- Package flood_it_pkg holds:
  - cmd_e enum (NONE, SELECT, UP, DOWN, LEFT, RIGHT; 3 bits).
  - Button index constants BTN_C=0, BTN_U=1, BTN_D=2, BTN_L=3, BTN_R=4.
- Sub-module btn_debounce: synchronizer, debounce counter and level output for a single bit, with parameter DEBOUNCE_CYCLES. Instantiated 5 times.
- Edge detection, priority, repeat FSM and buffer stay in the top of this block.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Raw U rises at edge 0, cmd_ready=1 -> cmd_valid=1, cmd_code=2, cmd_repeat=0 at edge 7 for exactly 1 cycle; btn_level[1]=1.
- Raw C pulses high for 3 cycles, then is low -> btn_level stays 0, no cmd_valid, overflow=0.
- Hold L, cmd_ready=1 -> press at edge 7; repeats (code 4, repeat=1) at edges 27, 35, 43. Release -> no further repeats and the FSM returns to R_IDLE.
- cmd_ready=0, press R then, after acceptance is still pending, press D -> cmd_code stays 5; overflow=1. ovf_clr pulse -> overflow=0.
- C and U rise in the same cycle -> one command with code 1; overflow=1; the repeat FSM stays R_IDLE (U lost).
- Hold D, assert rst_n=0 during R_PERIOD, release reset with D still held -> outputs 0 during reset; after release, code 3 arrives with repeat=0 after 7 edges.
